// File: rtl/aes_sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes unit: substitutes BPC bytes per cycle of a
// 128-bit state, direction chosen per transaction, with valid/ready on both sides.
module aes_sub_bytes_iter #(
  parameter int unsigned BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  localparam int unsigned NSTEP = 16 / BPC;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_check
      $error("aes_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] s;
    t = gf_inv(x);
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      s[i] = t[i] ^ t[(i + 4) % 8] ^ t[(i + 5) % 8] ^ t[(i + 6) % 8] ^ t[(i + 7) % 8];
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    logic [7:0] t;
    t = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      t[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
    end
    return gf_inv(t ^ 8'h05);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            mode;
  logic [0:127]    work;
  logic [0:127]    work_sub;
  logic            last_step;
  logic            accept;
  logic [7:0]      lane_in  [BPC];
  logic [7:0]      lane_out [BPC];

  assign last_step = (cnt == CW'(NSTEP - 1));
  assign accept    = in_valid && in_ready;

  for (genvar j = 0; j < BPC; j++) begin : g_lane
    logic [7:0] fwd;
    logic [7:0] inv;
    assign lane_in[j]  = work[7'(8 * (32'(cnt) * BPC + j)) +: 8];
    assign fwd         = sbox_fwd(lane_in[j]);
    assign inv         = sbox_inv(lane_in[j]);
    assign lane_out[j] = mode ? inv : fwd;
  end

  always_comb begin
    work_sub = work;
    for (int unsigned j = 0; j < BPC; j++) begin
      work_sub[7'(8 * (32'(cnt) * BPC + j)) +: 8] = lane_out[j];
    end
  end

  // in_ready in DONE follows out_ready so a result can drain and a new state load on one edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? SUB : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode      <= 1'b0;
      work      <= '0;
      out_state <= '0;
    end else if (accept) begin
      work <= in_state;
      mode <= in_mode;
      cnt  <= '0;
    end else if (state == SUB) begin
      work <= work_sub;
      cnt  <= last_step ? '0 : cnt + CW'(1);
      if (last_step) out_state <= work_sub;
    end
  end

endmodule
